stunir_position_unit: RTL
=========================

# stunir_position_unit

Parametrised successor to the generated single-result call modules: a start/done command unit that holds a position register and executes GET, SET, ADD and SUB commands over a configurable multi-cycle execute phase. It sits in the STUNIR FPGA output layer as the reusable building block that generated `get_position`-style wrappers instantiate. Unlike the fixed one-cycle predecessor, it has parametrised width and latency, carries an opcode and operand, rejects commands while busy, and optionally bounds the position.

## Interface
Parameters:
- `WIDTH`, 32: position, operand and result width; must be ≥ 2.
- `LATENCY`, 1: cycles spent in EXEC; must be ≥ 1.
- `POS_MIN`, 0: lower bound; used only with `STUNIR_POS_BOUNDS_EN`.
- `POS_MAX`, 2^WIDTH−1: upper bound; used only with `STUNIR_POS_BOUNDS_EN`. Requires POS_MIN ≤ POS_MAX.

Ports:
- `clk`  in  1  clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  command request, sampled each cycle.
- `op`  in  2  opcode: 00 GET, 01 SET, 10 ADD, 11 SUB.
- `operand`  in  WIDTH  unsigned operand for SET/ADD/SUB; ignored for GET.
- `busy`  out  1  high while in EXEC.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  WIDTH  position after the command; held until the next done.
- `position`  out  WIDTH  live position register.
- `ovf`  out  1  result was clamped; valid with done, held with result.
- `reject`  out  1  one-cycle pulse: start arrived while busy and was dropped.

## Operation
- States are IDLE, EXEC and DONE.
- IDLE or DONE with `start`=1: latch `op`/`operand`, load counter with LATENCY−1, and go to EXEC.
- IDLE with `start`=0: stay in IDLE.
- DONE with `start`=0: go to IDLE.
- EXEC with counter ≠ 0: decrement the counter.
- EXEC with counter = 0: compute, update `position`, load `result`/`ovf`, set `done`=1, and go to DONE.
- `done` clears on any cycle not leaving EXEC.
- `start` in EXEC: command discarded; `reject`=1 for the next cycle; the in-flight command is unaffected.
- GET: position unchanged; `result` = position.
- SET: position = operand.
- ADD: position + operand, computed in WIDTH+1 bits.
- SUB: position − operand, computed in WIDTH+1 bits.
- Without bounds, ADD/SUB results wrap modulo 2^WIDTH.
- `op` and `operand` are don't-care when not accepted.

## Timing
- Reset values: state IDLE; `busy`, `done`, `ovf`, `reject` = 0; `result` = 0.
- Reset value of `position` is 0, or POS_MIN with bounds.
- `rst` overrides `start` in the same cycle. `rst` in EXEC aborts the command with no done.
- For start sampled at edge T, `busy` is high from T+1 through T+LATENCY.
- The same start produces `done` and a new `result` in the cycle after edge T+LATENCY.
- `position` changes at that same edge; `result` equals the new `position` during the done cycle.
- Back-to-back throughput is one command per LATENCY+1 cycles. A start during DONE gives no idle bubble.
- `busy` is low during DONE.

## Configuration
- `STUNIR_POS_BOUNDS_EN` defined:
  - SET, ADD and SUB results are clamped to [POS_MIN, POS_MAX]. This includes ADD carry-out and SUB borrow.
  - `ovf`=1 with `done` when clamping occurred.
  - Reset position is POS_MIN.
- `STUNIR_POS_BOUNDS_EN` undefined:
  - Results wrap modulo 2^WIDTH.
  - POS_MIN/POS_MAX are ignored and `ovf` is tied 0.

## Structure
- Package `stunir_pos_pkg` holds:
  - the opcode typedef `pos_op_t` (GET/SET/ADD/SUB);
  - the state typedef `pos_state_t` (IDLE/EXEC/DONE);
  - shared localparams for opcode encodings.
- One sub-module, `stunir_latency_counter`, is natural. It takes a LATENCY-parameterised load and decrement, and outputs a zero flag that drives the EXEC exit.

## Test plan
- WIDTH=8, LATENCY=3. Reset, then SET 0x40 at cycle 0 → `busy` cycles 1–3; `done`=1 in cycle 4 with `result`=0x40 and `position`=0x40.
- ADD 0xF0 from 0x40, bounds off → `result`=0x30, `ovf`=0. Then SUB 0x31 → `result`=0xFF.
- Bounds on, POS_MIN=0x10, POS_MAX=0xE0:
  - ADD 0xF0 from 0x40 → `result`=0xE0, `ovf`=1.
  - SUB 0xFF → `result`=0x10, `ovf`=1.
  - GET → `ovf`=0.
- Start in each EXEC cycle → `reject` pulses each following cycle. The in-flight result is unchanged and no extra `done` occurs.
- Start held high continuously, LATENCY=3 → a `done` every 4 cycles with no IDLE visit.
- `rst` asserted in the second EXEC cycle of ADD 0x05 → no `done`. `position`=0, or POS_MIN with bounds; `busy`=0 the next cycle.

Source files
------------

// File: rtl/stunir_pos_pkg.sv
// stunir_pos_pkg: opcode/state types and encodings shared by the position unit
package stunir_pos_pkg;
    localparam logic [1:0] ENC_GET = 2'b00;
    localparam logic [1:0] ENC_SET = 2'b01;
    localparam logic [1:0] ENC_ADD = 2'b10;
    localparam logic [1:0] ENC_SUB = 2'b11;
    typedef enum logic [1:0] {
        OP_GET = ENC_GET,
        OP_SET = ENC_SET,
        OP_ADD = ENC_ADD,
        OP_SUB = ENC_SUB
    } pos_op_t;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } pos_state_t;
endpackage

// File: rtl/stunir_latency_counter.sv
// stunir_latency_counter: loadable down-counter whose zero flag ends the execute phase
module stunir_latency_counter #(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = load ? CW'(LATENCY - 1) : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign zero = cnt_q == '0;
endmodule

// File: rtl/stunir_position_unit.sv
// stunir_position_unit: start/done GET/SET/ADD/SUB position register unit;
// STUNIR_POS_BOUNDS_EN clamps results to [POS_MIN, POS_MAX] and reports ovf.
module stunir_position_unit
    import stunir_pos_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               LATENCY = 1,
    parameter logic [WIDTH-1:0] POS_MIN = '0,
    parameter logic [WIDTH-1:0] POS_MAX = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] position,
    output logic             ovf,
    output logic             reject
);
    if (WIDTH < 2 || LATENCY < 1 || POS_MIN > POS_MAX) begin : g_bad_params
        $error("stunir_position_unit: illegal WIDTH/LATENCY/POS_MIN/POS_MAX");
    end
`ifdef STUNIR_POS_BOUNDS_EN
    localparam logic [WIDTH-1:0] RST_POS = POS_MIN;
`else
    localparam logic [WIDTH-1:0] RST_POS = '0;
`endif
    pos_state_t       state_q, state_d;
    pos_op_t          op_q, op_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [WIDTH-1:0] position_q, position_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             reject_q, reject_d;
    logic             accept, finish, cnt_dec, cnt_zero;
    logic [WIDTH-1:0] new_pos;
    logic             new_ovf;

    stunir_latency_counter #(.LATENCY(LATENCY)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .dec  (cnt_dec),
        .zero (cnt_zero)
    );

`ifdef STUNIR_POS_BOUNDS_EN
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] raw;
    logic             carry, borrow, hi, lo;
    // carry/borrow force the clamp direction regardless of the wrapped low bits
    always_comb begin
        sum     = {1'b0, position_q} + {1'b0, operand_q};
        diff    = {1'b0, position_q} - {1'b0, operand_q};
        carry   = op_q == OP_ADD && sum[WIDTH];
        borrow  = op_q == OP_SUB && diff[WIDTH];
        raw     = op_q == OP_SET ? operand_q :
                  op_q == OP_ADD ? sum[WIDTH-1:0] :
                  op_q == OP_SUB ? diff[WIDTH-1:0] : position_q;
        hi      = op_q != OP_GET && !borrow && (carry || raw > POS_MAX);
        lo      = op_q != OP_GET && !carry && (borrow || raw < POS_MIN);
        new_pos = hi ? POS_MAX : lo ? POS_MIN : raw;
        new_ovf = hi || lo;
    end
`else
    always_comb begin
        new_pos = op_q == OP_SET ? operand_q :
                  op_q == OP_ADD ? position_q + operand_q :
                  op_q == OP_SUB ? position_q - operand_q : position_q;
        new_ovf = 1'b0;
    end
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        cnt_dec = 1'b0;
        case (state_q)
            ST_EXEC: begin
                finish  = cnt_zero;
                cnt_dec = !cnt_zero;
                state_d = cnt_zero ? ST_DONE : ST_EXEC;
            end
            default: begin
                accept  = start;
                state_d = start ? ST_EXEC : ST_IDLE;
            end
        endcase
    end

    always_comb begin
        op_d       = accept ? pos_op_t'(op) : op_q;
        operand_d  = accept ? operand : operand_q;
        position_d = finish ? new_pos : position_q;
        result_d   = finish ? new_pos : result_q;
        ovf_d      = finish ? new_ovf : ovf_q;
        done_d     = finish;
        reject_d   = start && state_q == ST_EXEC;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_GET;
            operand_q  <= '0;
            position_q <= RST_POS;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            operand_q  <= operand_d;
            position_q <= position_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            reject_q   <= reject_d;
        end
    end

    assign busy     = state_q == ST_EXEC;
    assign done     = done_q;
    assign result   = result_q;
    assign position = position_q;
    assign ovf      = ovf_q;
    assign reject   = reject_q;
endmodule
